kpd_ssd_multi: RTL and testbench
================================

KPD_SSD_MULTI -- requirements
Module: kpd_ssd_multi

Interface
REQ-001 Parameter NUM_DIGITS, default 2: digits in display buffer and multiplexed outputs; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 1000: clock cycles each keypad column is driven; legal value >= 2.
REQ-003 Parameter DB_SCANS, default 4: consecutive identical full scans required to accept a key; legal value >= 1.
REQ-004 Parameter REFRESH_DIV, default 1000: clock cycles each digit is displayed; legal value >= 1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-007 krow  input  4  keypad rows, active-low.
REQ-008 kcol  output  4  keypad column drive, active-low one-hot.
REQ-009 seg  output  7  segments, active-high; seg[0]=a through seg[6]=g.
REQ-010 dig_sel  output  NUM_DIGITS  digit enable, active-low one-hot.
REQ-011 key_valid  output  1  one-cycle pulse on key acceptance.
REQ-012 key_code  output  4  hex code of the last accepted key; held between acceptances.

Function
REQ-013 Scan FSM states COL0..COL3; each state drives its kcol bit low for SCAN_DIV cycles, then advances; COL3 wraps to COL0.
REQ-014 Rows sampled on the last cycle of each column state; four samples form one full scan.
REQ-015 Key map (row, col0..col3): r0 1 2 3 A; r1 4 5 6 B; r2 7 8 9 C; r3 0 F E D.
REQ-016 Scan result: NONE if no row low; KEY(code) if exactly one row low in exactly one column; GHOST otherwise.
REQ-017 Debounce counter increments on a KEY scan matching the previous scan's code, loads 1 on a differing KEY, clears on NONE or GHOST.
REQ-018 Acceptance occurs once when the counter reaches DB_SCANS; further acceptances are inhibited until a NONE scan occurs (no auto-repeat).
REQ-019 GHOST scans never produce acceptance and do not clear the inhibit.
REQ-020 On acceptance: key_valid high for exactly one cycle, key_code updated, and digit buffer shifted on that same edge (digit[i] <= digit[i-1], digit[0] <= code, oldest dropped).
REQ-021 Refresh counter counts 0..REFRESH_DIV-1; on wrap, the digit index advances 0..NUM_DIGITS-1 and wraps to 0.
REQ-022 dig_sel and seg are registered; both reflect current index and buffer content one cycle after any change.
REQ-023 Hex-to-segment (gfedcba) encoding: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, B=1111100, C=0111001, D=1011110, E=1111001, F=1110001.
REQ-024 When NUM_DIGITS=1, the buffer is a single register, the index is constant 0, and dig_sel is constantly 0.

Reset
REQ-025 While rst=0 at a clock edge: scan FSM to COL0, kcol=1110, all counters 0, inhibit cleared, all digits 0.
REQ-026 Reset output values: seg=0111111, dig_sel with only bit0 low, key_valid=0, key_code=0.
REQ-027 Reset asserted mid-scan or mid-debounce discards the partial scan and count; no key_valid pulse is produced during or on exit from reset.

Configuration
REQ-028 Macro KPD_CLEAR_EN defined: accepting key C clears all digits to 0 instead of shifting, while key_valid still pulses and key_code=C.
REQ-029 Macro KPD_CLEAR_EN undefined: key C is shifted in like every other key.

Verification
REQ-030 Use NUM_DIGITS=4, SCAN_DIV=4, DB_SCANS=2, REFRESH_DIV=8 for all scenarios below.
REQ-031 Hold key 5 (r1,col1) for 3 scans -> exactly one key_valid, key_code=5, digit0 segment value 1101101; no repeat until release.
REQ-032 Press 1, release, 2, release, 3, release, 4, release, 7 -> digits[3:0]=2,3,4,7; key 1 is dropped.
REQ-033 Press 4 and 6 together (r1, col0 and col2) -> no key_valid; release and press 9 -> key_code=9.
REQ-034 Assert rst=0 one cycle before the second matching scan of key A -> no pulse, outputs at reset values, kcol=1110.
REQ-035 Run 64 idle cycles -> dig_sel steps 1110,1101,1011,0111,1110 every 8 cycles; with KPD_CLEAR_EN, press C after entering 8 -> all digits 0, key_valid pulsed.

Source files
------------

// File: rtl/kpd_ssd_multi.sv
// 4x4 keypad scanner with debounce feeding a multiplexed seven-segment digit buffer.
// Optional build macro KPD_CLEAR_EN: accepting key C clears the buffer instead of shifting it in.
module kpd_ssd_multi #(
    parameter int NUM_DIGITS  = 2,
    parameter int SCAN_DIV    = 1000,
    parameter int DB_SCANS    = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            krow,
    output logic [3:0]            kcol,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  key_valid,
    output logic [3:0]            key_code
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DB_SCANS + 1);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_t;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'b0111111;
            4'h1: hex2seg = 7'b0000110;
            4'h2: hex2seg = 7'b1011011;
            4'h3: hex2seg = 7'b1001111;
            4'h4: hex2seg = 7'b1100110;
            4'h5: hex2seg = 7'b1101101;
            4'h6: hex2seg = 7'b1111101;
            4'h7: hex2seg = 7'b0000111;
            4'h8: hex2seg = 7'b1111111;
            4'h9: hex2seg = 7'b1101111;
            4'hA: hex2seg = 7'b1110111;
            4'hB: hex2seg = 7'b1111100;
            4'hC: hex2seg = 7'b0111001;
            4'hD: hex2seg = 7'b1011110;
            4'hE: hex2seg = 7'b1111001;
            4'hF: hex2seg = 7'b1110001;
            default: hex2seg = 7'b0000000;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'b0000: key_map = 4'h1;
            4'b0001: key_map = 4'h2;
            4'b0010: key_map = 4'h3;
            4'b0011: key_map = 4'hA;
            4'b0100: key_map = 4'h4;
            4'b0101: key_map = 4'h5;
            4'b0110: key_map = 4'h6;
            4'b0111: key_map = 4'hB;
            4'b1000: key_map = 4'h7;
            4'b1001: key_map = 4'h8;
            4'b1010: key_map = 4'h9;
            4'b1011: key_map = 4'hC;
            4'b1100: key_map = 4'h0;
            4'b1101: key_map = 4'hF;
            4'b1110: key_map = 4'hE;
            4'b1111: key_map = 4'hD;
            default: key_map = 4'h0;
        endcase
    endfunction

    col_state_t      state_r, state_next_s;
    logic [SW-1:0]   scan_cnt_r;
    logic            col_done_s, scan_end_s;
    logic [3:0]      kcol_r;
    logic [1:0]      hit_cnt_r, tot_sat_s, row_idx_s;
    logic [3:0]      hit_code_r, code_s, row_low_s;
    logic [2:0]      row_n_s, tot_s;
    logic [DW-1:0]   db_cnt_r, db_next_s;
    logic [3:0]      prev_code_r;
    logic            inhibit_r, accept_s, key_valid_r;
    logic [3:0]      key_code_r;
    logic [3:0]      digits_r [NUM_DIGITS];
    logic [3:0]      shift_s  [NUM_DIGITS];
    logic [RW-1:0]   ref_cnt_r;
    logic [IW-1:0]   idx_r;
    logic [6:0]      seg_r;
    logic [NUM_DIGITS-1:0] dig_sel_r;

    // Column sequencer next state: advance on the last cycle of each column.
    always_comb begin
        state_next_s = state_r;
        col_done_s   = (scan_cnt_r == SW'(SCAN_DIV - 1));
        if (col_done_s) begin
            case (state_r)
                COL0:    state_next_s = COL1;
                COL1:    state_next_s = COL2;
                COL2:    state_next_s = COL3;
                COL3:    state_next_s = COL0;
                default: state_next_s = COL0;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Row sample classification and debounce decision; hit count saturates at 2 (ghost).
    always_comb begin
        row_low_s = ~krow;
        row_n_s   = {2'b00, row_low_s[0]} + {2'b00, row_low_s[1]}
                  + {2'b00, row_low_s[2]} + {2'b00, row_low_s[3]};
        if (row_low_s[0])      row_idx_s = 2'd0;
        else if (row_low_s[1]) row_idx_s = 2'd1;
        else if (row_low_s[2]) row_idx_s = 2'd2;
        else                   row_idx_s = 2'd3;
        tot_s     = {1'b0, hit_cnt_r} + row_n_s;
        tot_sat_s = (tot_s > 3'd1) ? 2'd2 : tot_s[1:0];
        if (row_n_s == 3'd1) code_s = key_map(row_idx_s, state_r);
        else                 code_s = hit_code_r;
        scan_end_s = col_done_s && (state_r == COL3);
        if ((db_cnt_r != DW'(0)) && (code_s == prev_code_r)) begin
            db_next_s = (db_cnt_r == DW'(DB_SCANS)) ? db_cnt_r : db_cnt_r + 1'b1;
        end else begin
            db_next_s = DW'(1);
        end
        accept_s = scan_end_s && (tot_sat_s == 2'd1) && !inhibit_r
                 && (db_next_s == DW'(DB_SCANS));
    end

    // Candidate buffer contents after a shift-in of the accepted code.
    always_comb begin
        shift_s[0] = code_s;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            shift_s[i] = digits_r[i-1];
        end
    end

    // Scan state, column timer and per-scan hit accumulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= COL0;
            scan_cnt_r <= SW'(0);
            kcol_r     <= 4'b1110;
            hit_cnt_r  <= 2'd0;
            hit_code_r <= 4'h0;
        end else begin
            state_r    <= state_next_s;
            kcol_r     <= ~(4'b0001 << state_next_s);
            scan_cnt_r <= col_done_s ? SW'(0) : scan_cnt_r + 1'b1;
            if (scan_end_s) begin
                hit_cnt_r  <= 2'd0;
                hit_code_r <= 4'h0;
            end else if (col_done_s) begin
                hit_cnt_r  <= tot_sat_s;
                hit_code_r <= code_s;
            end
        end
    end

    // Debounce counter, repeat inhibit and key outputs; ghost scans leave the inhibit alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            db_cnt_r    <= DW'(0);
            prev_code_r <= 4'h0;
            inhibit_r   <= 1'b0;
            key_valid_r <= 1'b0;
            key_code_r  <= 4'h0;
        end else begin
            key_valid_r <= accept_s;
            if (accept_s) key_code_r <= code_s;
            if (scan_end_s) begin
                case (tot_sat_s)
                    2'd0: begin
                        db_cnt_r  <= DW'(0);
                        inhibit_r <= 1'b0;
                    end
                    2'd1: begin
                        db_cnt_r    <= db_next_s;
                        prev_code_r <= code_s;
                        if (accept_s) inhibit_r <= 1'b1;
                    end
                    default: db_cnt_r <= DW'(0);
                endcase
            end
        end
    end

    // Digit buffer update on acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits_r[i] <= 4'h0;
        end else if (accept_s) begin
`ifdef KPD_CLEAR_EN
            if (code_s == 4'hC) begin
                for (int i = 0; i < NUM_DIGITS; i++) digits_r[i] <= 4'h0;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) digits_r[i] <= shift_s[i];
            end
`else
            for (int i = 0; i < NUM_DIGITS; i++) digits_r[i] <= shift_s[i];
`endif
        end
    end

    // Display refresh timer, digit index and registered segment/select drive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_cnt_r <= RW'(0);
            idx_r     <= IW'(0);
            seg_r     <= 7'b0111111;
            dig_sel_r <= ~NUM_DIGITS'(1);
        end else begin
            seg_r     <= hex2seg(digits_r[idx_r]);
            dig_sel_r <= ~(NUM_DIGITS'(1) << idx_r);
            if (ref_cnt_r == RW'(REFRESH_DIV - 1)) begin
                ref_cnt_r <= RW'(0);
                idx_r     <= (idx_r == IW'(NUM_DIGITS - 1)) ? IW'(0) : idx_r + 1'b1;
            end else begin
                ref_cnt_r <= ref_cnt_r + 1'b1;
            end
        end
    end

    assign kcol      = kcol_r;
    assign seg       = seg_r;
    assign dig_sel   = dig_sel_r;
    assign key_valid = key_valid_r;
    assign key_code  = key_code_r;

endmodule

// File: tb/tb_kpd_ssd_multi.sv
// Self-checking bench for kpd_ssd_multi: a keypad matrix model drives rows, and a
// scan-level reference model predicts acceptances, key codes and the display.
module tb_kpd_ssd_multi;

    localparam int ND     = 4;
    localparam int SD     = 4;
    localparam int DB     = 2;
    localparam int RD     = 8;
    localparam int SCAN_T = 4 * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  krow;
    logic [3:0]  kcol;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int t;

    logic [3:0] kmap   [16];
    logic [6:0] segtab [16];

    logic [3:0] m_dig [ND];
    logic [3:0] m_code;
    logic [3:0] m_prev;
    int         streak;
    bit         m_inh;

    always #5 clk = ~clk;

    kpd_ssd_multi #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .DB_SCANS(DB), .REFRESH_DIV(RD)
    ) dut (
        .clk(clk), .rst(rst), .krow(krow), .kcol(kcol), .seg(seg),
        .dig_sel(dig_sel), .key_valid(key_valid), .key_code(key_code)
    );

    // Passive matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        krow = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kcol[c]) krow[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
        end
    endtask

    function automatic logic [15:0] kb(input int r, input int c);
        logic [15:0] one;
        one = 16'd1;
        return one << (r * 4 + c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
        m_code = 4'h0;
        m_prev = 4'h0;
        streak = 0;
        m_inh  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rst_kcol", kcol, 4'b1110);
            chk("rst_seg", seg, 7'b0111111);
            chk("rst_dig_sel", dig_sel, 4'b1110);
            chk("rst_key_valid", key_valid, 1'b0);
            chk("rst_key_code", key_code, 4'h0);
        end
        rst = 1'b1;
        t = -1;
        model_reset();
    endtask

    // Hold one key set for a whole scan and check every cycle against the model.
    task automatic run_scan(input logic [15:0] keys);
        logic [3:0] old_dig [ND];
        logic [3:0] old_code, code, e_sel, e_col;
        bit         acc;
        int         n, idx;
        pressed  = keys;
        n        = $countones(keys);
        code     = 4'h0;
        for (int b = 0; b < 16; b++) if (keys[b]) code = kmap[b];
        old_dig  = m_dig;
        old_code = m_code;
        acc      = 1'b0;
        if (n == 0) begin
            streak = 0;
            m_inh  = 1'b0;
        end else if (n > 1) begin
            streak = 0;
        end else begin
            if (streak > 0 && code == m_prev) streak++;
            else streak = 1;
            m_prev = code;
            if (streak == DB && !m_inh) begin
                acc    = 1'b1;
                m_inh  = 1'b1;
                m_code = code;
`ifdef KPD_CLEAR_EN
                if (code == 4'hC) begin
                    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
                end else begin
                    for (int i = ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
                    m_dig[0] = code;
                end
`else
                for (int i = ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
                m_dig[0] = code;
`endif
            end
        end
        for (int i = 0; i < SCAN_T; i++) begin
            tick();
            idx   = (t / RD) % ND;
            e_sel = ~(4'b0001 << idx);
            e_col = ~(4'b0001 << (((t + 1) / SD) % 4));
            chk("dig_sel", dig_sel, e_sel);
            chk("seg", seg, segtab[old_dig[idx]]);
            chk("kcol", kcol, e_col);
            chk("key_valid", key_valid, (i == SCAN_T - 1) && acc);
            chk("key_code", key_code, (i == SCAN_T - 1) ? m_code : old_code);
        end
    endtask

    initial begin
        int keys_r [5];
        int keys_c [5];
        kmap   = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
        segtab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                   7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                   7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                   7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        keys_r = '{0, 0, 0, 1, 2};
        keys_c = '{0, 1, 2, 0, 0};
        pressed = 16'h0000;
        t = -1;
        do_reset(3);

        // Key 5 held for three scans: a single acceptance, no repeat.
        for (int s = 0; s < 3; s++) run_scan(kb(1, 1));
        run_scan(16'h0000);
        chk("kc_5", key_code, 4'h5);

        // 1,2,3,4,7 with releases: oldest digit falls off.
        for (int k = 0; k < 5; k++) begin
            run_scan(kb(keys_r[k], keys_c[k]));
            run_scan(kb(keys_r[k], keys_c[k]));
            run_scan(16'h0000);
        end
        run_scan(16'h0000);
        run_scan(16'h0000);
        chk("kc_7", key_code, 4'h7);

        // Keys 4 and 6 together are a ghost; then key 9 is accepted.
        for (int s = 0; s < 3; s++) run_scan(kb(1, 0) | kb(1, 2));
        run_scan(16'h0000);
        run_scan(kb(2, 2));
        run_scan(kb(2, 2));
        run_scan(16'h0000);
        chk("kc_9", key_code, 4'h9);

        // Reset one cycle before the second matching scan of key A.
        run_scan(kb(0, 3));
        pressed = kb(0, 3);
        for (int i = 0; i < SCAN_T - 2; i++) begin
            tick();
            chk("kv_pre_rst", key_valid, 1'b0);
        end
        pressed = 16'h0000;
        do_reset(3);
        run_scan(16'h0000);
        run_scan(kb(0, 3));
        run_scan(kb(0, 3));
        run_scan(16'h0000);

        // Idle display refresh over 64 cycles.
        for (int s = 0; s < 4; s++) run_scan(16'h0000);

        // Key 8 then key C.
        run_scan(kb(2, 1));
        run_scan(kb(2, 1));
        run_scan(16'h0000);
        run_scan(kb(2, 3));
        run_scan(kb(2, 3));
        run_scan(16'h0000);
        run_scan(16'h0000);
        chk("kc_c", key_code, 4'hC);

        // Randomized press patterns: idle, single keys and multi-key ghosts.
        for (int it = 0; it < 30; it++) begin
            logic [15:0] ks;
            int sel, b1, b2, hold;
            sel  = $urandom_range(0, 9);
            b1   = $urandom_range(0, 15);
            b2   = (b1 + $urandom_range(1, 15)) % 16;
            hold = $urandom_range(1, 4);
            if (sel < 4)      ks = 16'h0000;
            else if (sel < 9) ks = kb(b1 / 4, b1 % 4);
            else              ks = kb(b1 / 4, b1 % 4) | kb(b2 / 4, b2 % 4);
            for (int h = 0; h < hold; h++) run_scan(ks);
        end
        run_scan(16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
